// File: rtl/gol_led_scanner.sv
// Row-multiplexed 8x8 LED driver for Game of Life generations. It captures a snapshot over a
// valid/ready handshake, scans it row by row, and reports the generation count and population.
module gol_led_scanner #(
    parameter int unsigned DWELL_CYCLES = 4,
    parameter int unsigned GEN_WIDTH    = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [63:0]          grid_in,
    input  logic                 grid_valid,
    output logic                 grid_ready,
    output logic [7:0]           row_sel,
    output logic [7:0]           col_data,
    output logic                 frame_done,
    output logic [GEN_WIDTH-1:0] gen_count,
    output logic [6:0]           alive_count
);

    localparam int unsigned DW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);

    typedef enum logic {StIdle, StScan} state_t;

    state_t               r_state;
    logic [63:0]          r_frame;
    logic [2:0]           r_row_idx;
    logic [DW-1:0]        r_dwell_cnt;
    logic [GEN_WIDTH-1:0] r_gen_count;
    logic [6:0]           r_alive_count;
    logic                 r_frame_done;

    logic                 w_last_dwell;
    logic                 w_final;
    logic                 w_accept;
    logic                 w_capture;
    logic [6:0]           w_pop;

    assign w_last_dwell = (r_dwell_cnt == DWELL_LAST);
    assign w_final      = (r_state == StScan) && (r_row_idx == 3'd7) && w_last_dwell;
    assign w_accept     = (r_state == StIdle) || w_final;
    assign w_capture    = grid_valid && w_accept;

    always_comb begin
        w_pop = 7'd0;
        for (int i = 0; i < 64; i++) begin
            w_pop = w_pop + 7'(grid_in[i]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= StIdle;
            r_frame       <= 64'd0;
            r_row_idx     <= 3'd0;
            r_dwell_cnt   <= '0;
            r_gen_count   <= '0;
            r_alive_count <= 7'd0;
            r_frame_done  <= 1'b0;
        end else begin
            r_frame_done <= w_final;
            if (w_capture) begin
                // Capture in the last scan cycle restarts at row 0 with no blank gap.
                r_frame       <= grid_in;
                r_alive_count <= w_pop;
                r_gen_count   <= r_gen_count + 1'b1;
                r_row_idx     <= 3'd0;
                r_dwell_cnt   <= '0;
                r_state       <= StScan;
            end else if (r_state == StScan) begin
                if (w_last_dwell) begin
                    r_dwell_cnt <= '0;
                    r_row_idx   <= r_row_idx + 3'd1;
                    if (r_row_idx == 3'd7) begin
                        r_state <= StIdle;
                    end
                end else begin
                    r_dwell_cnt <= r_dwell_cnt + 1'b1;
                end
            end
        end
    end

    // Row r lives in frame[63-8r -: 8]; ~row_idx gives 7-r for the 3-bit index.
    always_comb begin
        row_sel  = 8'd0;
        col_data = 8'd0;
        if (r_state == StScan) begin
            row_sel  = 8'd1 << r_row_idx;
            col_data = r_frame[{~r_row_idx, 3'b000} +: 8];
        end
    end

    assign grid_ready  = !reset && w_accept;
    assign frame_done  = r_frame_done;
    assign gen_count   = r_gen_count;
    assign alive_count = r_alive_count;

endmodule
